branch_resolver: RTL and testbench

BRANCH_RESOLVER -- requirements
Module: branch_resolver

---
 rtl/branch_pkg.sv | 24 ++
 rtl/bp_meta_stage.sv | 33 +++
 rtl/branch_resolver.sv | 151 +++++++++++++++
 tb/tb_branch_resolver.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types for the branch resolution pipeline: history width, the
// per-instruction prediction metadata carried from IF to EX, and a
// saturating increment used by the statistics counters.
package branch_pkg;

    localparam int BHR_W = 8;

    typedef struct packed {
        logic [31:0]      pc;
        logic             is_branch;
        logic             is_jump;
        logic             predict_taken;
        logic             use_predicted;
        logic [31:0]      predicted_pc;
        logic [BHR_W-1:0] bhr;
        logic             loc_predict_taken;
        logic             glob_predict_taken;
    } bp_meta_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/bp_meta_stage.sv
// One pipeline register for prediction metadata. Stall holds the stage,
// flush drops the incoming entry (valid goes low), reset clears everything.
module bp_meta_stage
    import branch_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     stall,
    input  logic     flush,
    input  logic     valid_in,
    input  bp_meta_t meta_in,
    output logic     valid_out,
    output bp_meta_t meta_out
);

    // Stage register: reset beats stall, stall beats flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            meta_out  <= '0;
        end else if (stall) begin
            valid_out <= valid_out;
            meta_out  <= meta_out;
        end else if (flush) begin
            valid_out <= 1'b0;
            meta_out  <= meta_in;
        end else begin
            valid_out <= valid_in;
            meta_out  <= meta_in;
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// Carries IF prediction metadata through ID and EX, resolves the EX entry
// against the computed target/condition, issues fetch redirects on a
// mispredict, produces registered predictor-update pulses and keeps
// saturating branch/mispredict statistics.
module branch_resolver
    import branch_pkg::*;
#(
    parameter int BHR_W = branch_pkg::BHR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    input  logic [31:0]      pc_if,
    input  logic             is_branch_if,
    input  logic             is_jump_if,
    input  logic             predict_taken,
    input  logic             loc_predict_taken_if,
    input  logic             glob_predict_taken_if,
    input  logic [31:0]      predicted_pc,
    input  logic             use_predicted,
    input  logic [BHR_W-1:0] bhr_if,
    input  logic             stall,
    input  logic [31:0]      ex_target,
    input  logic             cmp_out,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             is_branch_ex,
    output logic             is_jump_ex,
    output logic [31:0]      pc_ex,
    output logic [31:0]      branch_pc_ex,
    output logic             cmp_out_ex,
    output logic [BHR_W-1:0] bhr_ex,
    output logic             loc_predict_taken_ex,
    output logic             glob_predict_taken_ex,
    output logic [31:0]      branch_count,
    output logic [31:0]      mispredict_count
);

    bp_meta_t if_meta;
    bp_meta_t id_meta;
    bp_meta_t ex_meta;
    logic     id_valid;
    logic     ex_valid;

    logic     resolving;
    logic     res_jump;
    logic     res_branch;
    logic     eff_taken;
    logic     mispredict;

    // Pack the IF-side metadata into the shared struct.
    always_comb begin
        if_meta                    = '0;
        if_meta.pc                 = pc_if;
        if_meta.is_branch          = is_branch_if;
        if_meta.is_jump            = is_jump_if;
        if_meta.predict_taken      = predict_taken;
        if_meta.use_predicted      = use_predicted;
        if_meta.predicted_pc       = predicted_pc;
        if_meta.bhr                = bhr_if;
        if_meta.loc_predict_taken  = loc_predict_taken_if;
        if_meta.glob_predict_taken = glob_predict_taken_if;
    end

    // A redirect kills both the younger entry in ID and the one arriving from IF.
    bp_meta_stage u_id_stage (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (redirect),
        .valid_in  (if_valid),
        .meta_in   (if_meta),
        .valid_out (id_valid),
        .meta_out  (id_meta)
    );

    bp_meta_stage u_ex_stage (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (redirect),
        .valid_in  (id_valid),
        .meta_in   (id_meta),
        .valid_out (ex_valid),
        .meta_out  (ex_meta)
    );

    // Resolve the EX entry; a jump flag wins over a branch flag.
    always_comb begin
        resolving  = ex_valid && !stall && !rst;
        res_jump   = ex_meta.is_jump;
        res_branch = ex_meta.is_branch && !ex_meta.is_jump;
        eff_taken  = ex_meta.predict_taken && ex_meta.use_predicted;
        mispredict = 1'b0;
        if (res_jump) begin
            mispredict = !ex_meta.use_predicted || (ex_meta.predicted_pc != ex_target);
        end else if (res_branch) begin
            mispredict = (cmp_out != eff_taken) ||
                         (cmp_out && eff_taken && (ex_meta.predicted_pc != ex_target));
        end else begin
            mispredict = ex_meta.use_predicted;
        end

        redirect    = resolving && mispredict;
        redirect_pc = 32'd0;
        if (redirect) begin
            redirect_pc = (res_jump || cmp_out) ? ex_target : ex_meta.pc + 32'd4;
        end
    end

    // Predictor update: flags pulse for one cycle, payload holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            is_branch_ex          <= 1'b0;
            is_jump_ex            <= 1'b0;
            pc_ex                 <= '0;
            branch_pc_ex          <= '0;
            cmp_out_ex            <= 1'b0;
            bhr_ex                <= '0;
            loc_predict_taken_ex  <= 1'b0;
            glob_predict_taken_ex <= 1'b0;
        end else begin
            is_branch_ex <= resolving && res_branch;
            is_jump_ex   <= resolving && res_jump;
            if (resolving && (res_branch || res_jump)) begin
                pc_ex                 <= ex_meta.pc;
                branch_pc_ex          <= ex_target;
                cmp_out_ex            <= cmp_out || res_jump;
                bhr_ex                <= ex_meta.bhr;
                loc_predict_taken_ex  <= ex_meta.loc_predict_taken;
                glob_predict_taken_ex <= ex_meta.glob_predict_taken;
            end
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (resolving && (res_branch || res_jump)) begin
                branch_count <= sat_inc(branch_count);
            end
            if (redirect) begin
                mispredict_count <= sat_inc(mispredict_count);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: hand-computed expectations checked
// with immediate assertions after each step.
module tb_branch_resolver;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [31:0] pc_if;
    logic        is_branch_if;
    logic        is_jump_if;
    logic        predict_taken;
    logic        loc_predict_taken_if;
    logic        glob_predict_taken_if;
    logic [31:0] predicted_pc;
    logic        use_predicted;
    logic [7:0]  bhr_if;
    logic        stall;
    logic [31:0] ex_target;
    logic        cmp_out;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        is_branch_ex;
    logic        is_jump_ex;
    logic [31:0] pc_ex;
    logic [31:0] branch_pc_ex;
    logic        cmp_out_ex;
    logic [7:0]  bhr_ex;
    logic        loc_predict_taken_ex;
    logic        glob_predict_taken_ex;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int n_tests = 0;
    int n_fail  = 0;

    branch_resolver dut (
        .clk                   (clk),
        .rst                   (rst),
        .if_valid              (if_valid),
        .pc_if                 (pc_if),
        .is_branch_if          (is_branch_if),
        .is_jump_if            (is_jump_if),
        .predict_taken         (predict_taken),
        .loc_predict_taken_if  (loc_predict_taken_if),
        .glob_predict_taken_if (glob_predict_taken_if),
        .predicted_pc          (predicted_pc),
        .use_predicted         (use_predicted),
        .bhr_if                (bhr_if),
        .stall                 (stall),
        .ex_target             (ex_target),
        .cmp_out               (cmp_out),
        .redirect              (redirect),
        .redirect_pc           (redirect_pc),
        .is_branch_ex          (is_branch_ex),
        .is_jump_ex            (is_jump_ex),
        .pc_ex                 (pc_ex),
        .branch_pc_ex          (branch_pc_ex),
        .cmp_out_ex            (cmp_out_ex),
        .bhr_ex                (bhr_ex),
        .loc_predict_taken_ex  (loc_predict_taken_ex),
        .glob_predict_taken_ex (glob_predict_taken_ex),
        .branch_count          (branch_count),
        .mispredict_count      (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then changed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic present(input logic [31:0] pc, input logic br, input logic jp,
                           input logic pt, input logic up, input logic [31:0] ppc,
                           input logic [7:0] bhr, input logic loc, input logic glob);
        if_valid              = 1'b1;
        pc_if                 = pc;
        is_branch_if          = br;
        is_jump_if            = jp;
        predict_taken         = pt;
        use_predicted         = up;
        predicted_pc          = ppc;
        bhr_if                = bhr;
        loc_predict_taken_if  = loc;
        glob_predict_taken_if = glob;
    endtask

    task automatic idle();
        if_valid     = 1'b0;
        is_branch_if = 1'b0;
        is_jump_if   = 1'b0;
        use_predicted = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        ex_target = 32'd0;
        cmp_out = 1'b0;
        pc_if = 32'd0;
        predict_taken = 1'b0;
        predicted_pc = 32'd0;
        bhr_if = 8'd0;
        loc_predict_taken_if = 1'b0;
        glob_predict_taken_if = 1'b0;
        idle();
        tick();
        tick();
        rst = 1'b0;
        settle();
        chk("rst_redirect", {31'd0, redirect}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_is_branch_ex", {31'd0, is_branch_ex}, 32'd0);
        chk("rst_branch_count", branch_count, 32'd0);
        chk("rst_mispredict_count", mispredict_count, 32'd0);

        // Correctly predicted taken branch.
        present(32'h100, 1, 0, 1, 1, 32'h140, 8'hA5, 1, 0);
        tick();
        idle();
        tick();
        ex_target = 32'h140;
        cmp_out   = 1'b1;
        settle();
        chk("ok_redirect", {31'd0, redirect}, 32'd0);
        tick();
        chk("ok_is_branch_ex", {31'd0, is_branch_ex}, 32'd1);
        chk("ok_is_jump_ex", {31'd0, is_jump_ex}, 32'd0);
        chk("ok_pc_ex", pc_ex, 32'h100);
        chk("ok_branch_pc_ex", branch_pc_ex, 32'h140);
        chk("ok_cmp_out_ex", {31'd0, cmp_out_ex}, 32'd1);
        chk("ok_bhr_ex", {24'd0, bhr_ex}, 32'hA5);
        chk("ok_loc_ex", {31'd0, loc_predict_taken_ex}, 32'd1);
        chk("ok_glob_ex", {31'd0, glob_predict_taken_ex}, 32'd0);
        chk("ok_branch_count", branch_count, 32'd1);
        chk("ok_mispredict_count", mispredict_count, 32'd0);
        tick();
        chk("ok_pulse_ends", {31'd0, is_branch_ex}, 32'd0);
        chk("ok_pc_ex_hold", pc_ex, 32'h100);

        // Not-taken prediction, actually taken; younger entries get flushed.
        present(32'h200, 1, 0, 0, 1, 32'h204, 8'h11, 0, 1);
        tick();
        present(32'h204, 1, 0, 0, 0, 32'h0, 8'h22, 0, 0);
        tick();
        present(32'h208, 1, 0, 0, 0, 32'h0, 8'h33, 0, 0);
        ex_target = 32'h180;
        cmp_out   = 1'b1;
        settle();
        chk("mp_redirect", {31'd0, redirect}, 32'd1);
        chk("mp_redirect_pc", redirect_pc, 32'h180);
        tick();
        idle();
        settle();
        chk("mp_flushed_no_redirect", {31'd0, redirect}, 32'd0);
        chk("mp_is_branch_ex", {31'd0, is_branch_ex}, 32'd1);
        chk("mp_bhr_ex", {24'd0, bhr_ex}, 32'h11);
        chk("mp_branch_count", branch_count, 32'd2);
        chk("mp_mispredict_count", mispredict_count, 32'd1);
        tick();
        tick();
        chk("mp_flush_branch_count", branch_count, 32'd2);
        chk("mp_flush_no_pulse", {31'd0, is_branch_ex}, 32'd0);

        // Predicted taken at top of address space, not taken: pc+4 wraps.
        present(32'hFFFF_FFFC, 1, 0, 1, 1, 32'h1000, 8'h44, 1, 1);
        tick();
        idle();
        tick();
        ex_target = 32'h1000;
        cmp_out   = 1'b0;
        settle();
        chk("wrap_redirect", {31'd0, redirect}, 32'd1);
        chk("wrap_redirect_pc", redirect_pc, 32'h0);
        tick();
        chk("wrap_cmp_out_ex", {31'd0, cmp_out_ex}, 32'd0);
        chk("wrap_counts", {branch_count[15:0], mispredict_count[15:0]}, {16'd3, 16'd2});

        // Jump with no prediction.
        present(32'h300, 0, 1, 0, 0, 32'h0, 8'h55, 0, 0);
        tick();
        idle();
        tick();
        ex_target = 32'h400;
        cmp_out   = 1'b0;
        settle();
        chk("jmp_redirect", {31'd0, redirect}, 32'd1);
        chk("jmp_redirect_pc", redirect_pc, 32'h400);
        tick();
        chk("jmp_is_jump_ex", {31'd0, is_jump_ex}, 32'd1);
        chk("jmp_is_branch_ex", {31'd0, is_branch_ex}, 32'd0);
        chk("jmp_cmp_out_ex", {31'd0, cmp_out_ex}, 32'd1);
        chk("jmp_counts", {branch_count[15:0], mispredict_count[15:0]}, {16'd4, 16'd3});

        // Both flags set: treated as a correctly predicted jump.
        present(32'h500, 1, 1, 1, 1, 32'h600, 8'h66, 0, 0);
        tick();
        idle();
        tick();
        ex_target = 32'h600;
        cmp_out   = 1'b0;
        settle();
        chk("both_redirect", {31'd0, redirect}, 32'd0);
        tick();
        chk("both_is_jump_ex", {31'd0, is_jump_ex}, 32'd1);
        chk("both_is_branch_ex", {31'd0, is_branch_ex}, 32'd0);
        chk("both_counts", {branch_count[15:0], mispredict_count[15:0]}, {16'd5, 16'd3});

        // Non-control instruction that was predicted: redirect to pc+4.
        present(32'h700, 0, 0, 1, 1, 32'h780, 8'h77, 0, 0);
        tick();
        idle();
        tick();
        ex_target = 32'h780;
        cmp_out   = 1'b0;
        settle();
        chk("nc_redirect", {31'd0, redirect}, 32'd1);
        chk("nc_redirect_pc", redirect_pc, 32'h704);
        tick();
        chk("nc_no_pulse", {30'd0, is_branch_ex, is_jump_ex}, 32'd0);
        chk("nc_counts", {branch_count[15:0], mispredict_count[15:0]}, {16'd5, 16'd4});

        // Mispredicting branch held in EX by a 3-cycle stall.
        present(32'h800, 1, 0, 0, 0, 32'h0, 8'h88, 0, 0);
        tick();
        idle();
        tick();
        ex_target = 32'h900;
        cmp_out   = 1'b1;
        stall     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("stall_no_redirect", {31'd0, redirect}, 32'd0);
            tick();
        end
        chk("stall_counts", {branch_count[15:0], mispredict_count[15:0]}, {16'd5, 16'd4});
        chk("stall_no_pulse", {31'd0, is_branch_ex}, 32'd0);
        stall = 1'b0;
        settle();
        chk("stall_release_redirect", {31'd0, redirect}, 32'd1);
        chk("stall_release_pc", redirect_pc, 32'h900);
        tick();
        chk("stall_is_branch_ex", {31'd0, is_branch_ex}, 32'd1);
        chk("stall_counts_after", {branch_count[15:0], mispredict_count[15:0]}, {16'd6, 16'd5});
        settle();
        chk("stall_single_redirect", {31'd0, redirect}, 32'd0);
        tick();
        chk("stall_single_count", mispredict_count, 32'd5);

        // Reset with entries in ID and EX: everything discarded.
        present(32'hA00, 1, 0, 0, 0, 32'h0, 8'h99, 1, 1);
        tick();
        present(32'hA04, 1, 0, 0, 0, 32'h0, 8'h9A, 1, 1);
        tick();
        idle();
        ex_target = 32'hB00;
        cmp_out   = 1'b1;
        rst       = 1'b1;
        settle();
        chk("rstop_redirect_during", {31'd0, redirect}, 32'd0);
        tick();
        rst = 1'b0;
        settle();
        chk("rstop_redirect", {31'd0, redirect}, 32'd0);
        chk("rstop_pulse", {30'd0, is_branch_ex, is_jump_ex}, 32'd0);
        chk("rstop_branch_count", branch_count, 32'd0);
        chk("rstop_mispredict_count", mispredict_count, 32'd0);
        chk("rstop_pc_ex", pc_ex, 32'd0);
        tick();
        chk("rstop_redirect_next", {31'd0, redirect}, 32'd0);
        chk("rstop_pulse_next", {30'd0, is_branch_ex, is_jump_ex}, 32'd0);
        chk("rstop_counts_next", {branch_count[15:0], mispredict_count[15:0]}, 32'd0);
        tick();
        chk("rstop_counts_late", {branch_count[15:0], mispredict_count[15:0]}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
